// File: rtl/vend_fsm_param.sv
// vend_fsm_param
//
// Parametrised vending controller. Coins of several values build up a
// saturating credit. A selection vends one of NUM_PROD products, each with
// its own price. Leftover credit is returned one unit per cycle, either
// automatically after a vend or on cancel/inactivity timeout.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   coin_valid    one-cycle strobe: a coin is present
//   coin_amt      value of that coin, in units
//   sel_valid     one-cycle strobe: product selection
//   sel_idx       selected product
//   cancel        one-cycle strobe: refund request
//   credit        current credit (registered)
//   coin_acc      pulse: coin accepted
//   coin_rej      pulse: coin rejected to the return chute
//   err_funds     pulse: selection refused (credit too low or bad index)
//   disp_valid    high while dispensing
//   disp_idx      product being dispensed, stable while disp_valid
//   change_pulse  one pulse per unit of credit returned
//   busy          high while vending or returning change
module vend_fsm_param #(
  parameter int CREDIT_W = 4,
  parameter int AMT_W = 3,
  parameter int MAX_CREDIT = 12,
  parameter int NUM_PROD = 4,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int VEND_CYCLES = 3,
  parameter int AUTO_CHANGE = 1,
  parameter int TIMEOUT = 255,
  localparam int SEL_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [AMT_W-1:0]    coin_amt,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_idx,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_acc,
  output logic                coin_rej,
  output logic                err_funds,
  output logic                disp_valid,
  output logic [SEL_W-1:0]    disp_idx,
  output logic                change_pulse,
  output logic                busy
);

  localparam int VC_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [VC_W-1:0]     VC_LAST = VC_W'(VEND_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W:0]   MAX_L = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [SEL_W:0]      NUM_PROD_L = (SEL_W + 1)'(NUM_PROD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t              state;
  logic [VC_W-1:0]     vend_cnt;
  logic [TO_W-1:0]     idle_cnt;

  // Unpack the price table once so the selection path is a plain mux.
  logic [CREDIT_W-1:0] price_tab [NUM_PROD];
  for (genvar gi = 0; gi < NUM_PROD; gi++) begin : g_price
    assign price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
  end

  logic                sel_in_range;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                timeout_hit;

  assign sel_in_range = ({1'b0, sel_idx} < NUM_PROD_L);
  assign sel_price    = sel_in_range ? price_tab[sel_idx] : '0;
  assign sel_ok       = sel_in_range && (credit >= sel_price);
  // One extra bit so an overflowing sum is seen as too large, not wrapped.
  assign coin_sum     = (CREDIT_W + 1)'(credit) + (CREDIT_W + 1)'(coin_amt);
  assign coin_ok      = coin_valid && (coin_amt != '0) && (coin_sum <= MAX_L);
  assign timeout_hit  = (TIMEOUT != 0) && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      credit       <= '0;
      coin_acc     <= 1'b0;
      coin_rej     <= 1'b0;
      err_funds    <= 1'b0;
      disp_valid   <= 1'b0;
      disp_idx     <= '0;
      change_pulse <= 1'b0;
      busy         <= 1'b0;
      vend_cnt     <= '0;
      idle_cnt     <= '0;
    end else begin
      coin_acc     <= 1'b0;
      coin_rej     <= 1'b0;
      err_funds    <= 1'b0;
      change_pulse <= 1'b0;
      case (state)
        S_IDLE, S_HOLD: begin
          // Idle counter clears unless this cycle is a quiet HOLD cycle.
          idle_cnt <= '0;
          if (cancel) begin
            coin_rej <= coin_valid;
            if (state == S_HOLD) begin
              state <= S_CHANGE;
              busy  <= 1'b1;
            end
          end else if (sel_valid) begin
            coin_rej <= coin_valid;
            if (sel_ok) begin
              credit     <= credit - sel_price;
              disp_idx   <= sel_idx;
              disp_valid <= 1'b1;
              vend_cnt   <= '0;
              state      <= S_VEND;
              busy       <= 1'b1;
            end else begin
              err_funds <= 1'b1;
            end
          end else if (coin_ok) begin
            // An accepted coin beats a timeout landing in the same cycle.
            credit   <= coin_sum[CREDIT_W-1:0];
            coin_acc <= 1'b1;
            state    <= S_HOLD;
          end else begin
            coin_rej <= coin_valid;
            if ((state == S_HOLD) && (TIMEOUT != 0)) begin
              if (timeout_hit) begin
                state <= S_CHANGE;
                busy  <= 1'b1;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
          end
        end
        S_VEND: begin
          coin_rej <= coin_valid;
          if (vend_cnt == VC_LAST) begin
            disp_valid <= 1'b0;
            if (credit == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (AUTO_CHANGE != 0) begin
              state <= S_CHANGE;
            end else begin
              state <= S_HOLD;
              busy  <= 1'b0;
            end
          end else begin
            vend_cnt <= vend_cnt + 1'b1;
          end
        end
        S_CHANGE: begin
          coin_rej     <= coin_valid;
          change_pulse <= 1'b1;
          credit       <= credit - 1'b1;
          // Leave on the cycle the last unit goes out.
          if (credit == CREDIT_W'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Testbench for vend_fsm_param. Three instances share one stimulus stream:
// dut0 default, dut1 keeps leftover credit, dut2 has an 8-cycle timeout.
module tb_vend_fsm_param;
  localparam int ND = 3;
  localparam int VEND_N = 3;
  localparam int MAXC = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       coin_valid;
  logic [2:0] coin_amt;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       cancel;

  logic [3:0]    credit_w [ND];
  logic [1:0]    disp_idx_w [ND];
  logic [ND-1:0] coin_acc_w, coin_rej_w, err_funds_w, disp_valid_w;
  logic [ND-1:0] change_pulse_w, busy_w;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    vend_fsm_param #(
      .AUTO_CHANGE((gi == 1) ? 0 : 1),
      .TIMEOUT((gi == 2) ? 8 : 255)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .coin_valid(coin_valid),
      .coin_amt(coin_amt),
      .sel_valid(sel_valid),
      .sel_idx(sel_idx),
      .cancel(cancel),
      .credit(credit_w[gi]),
      .coin_acc(coin_acc_w[gi]),
      .coin_rej(coin_rej_w[gi]),
      .err_funds(err_funds_w[gi]),
      .disp_valid(disp_valid_w[gi]),
      .disp_idx(disp_idx_w[gi]),
      .change_pulse(change_pulse_w[gi]),
      .busy(busy_w[gi])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Behavioural model: credit, remaining dispense cycles, refund-in-progress
  // flag and quiet-cycle count per instance.
  int m_credit [ND];
  int m_vleft  [ND];
  int m_idle   [ND];
  int m_idx    [ND];
  bit m_refund [ND];
  bit e_acc [ND], e_rej [ND], e_err [ND], e_chg [ND], e_disp [ND], e_busy [ND];

  int n_chg  [ND];
  int n_disp [ND];

  function automatic int price_of(input int i);
    case (i)
      0: return 3;
      1: return 4;
      2: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic bit auto_of(input int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic int timeout_of(input int k);
    return (k == 2) ? 8 : 255;
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 60)
        $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", name, k, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit counted;
    int amt;
    for (int k = 0; k < ND; k++) begin
      e_acc[k] = 0; e_rej[k] = 0; e_err[k] = 0; e_chg[k] = 0;
      if (rst) begin
        m_credit[k] = 0; m_vleft[k] = 0; m_idle[k] = 0; m_idx[k] = 0; m_refund[k] = 0;
      end else if (m_vleft[k] > 0) begin
        e_rej[k] = coin_valid;
        m_vleft[k]--;
        if (m_vleft[k] == 0 && m_credit[k] > 0 && auto_of(k)) m_refund[k] = 1;
      end else if (m_refund[k]) begin
        e_rej[k] = coin_valid;
        e_chg[k] = 1;
        m_credit[k]--;
        if (m_credit[k] == 0) m_refund[k] = 0;
      end else begin
        counted = 0;
        amt = int'(coin_amt);
        if (cancel) begin
          e_rej[k] = coin_valid;
          if (m_credit[k] > 0) m_refund[k] = 1;
        end else if (sel_valid) begin
          e_rej[k] = coin_valid;
          if (m_credit[k] >= price_of(int'(sel_idx))) begin
            m_credit[k] -= price_of(int'(sel_idx));
            m_idx[k] = int'(sel_idx);
            m_vleft[k] = VEND_N;
          end else begin
            e_err[k] = 1;
          end
        end else if (coin_valid && amt != 0 && m_credit[k] + amt <= MAXC) begin
          m_credit[k] += amt;
          e_acc[k] = 1;
        end else begin
          e_rej[k] = coin_valid;
          if (m_credit[k] > 0) begin
            m_idle[k]++;
            counted = 1;
            if (m_idle[k] == timeout_of(k)) begin
              m_refund[k] = 1;
              counted = 0;
            end
          end
        end
        if (!counted) m_idle[k] = 0;
      end
      e_disp[k] = (m_vleft[k] > 0);
      e_busy[k] = (m_vleft[k] > 0) || m_refund[k];
    end
  endtask

  // Single compare process: every output of every instance, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < ND; k++) begin
        chk("credit", k, int'(credit_w[k]), m_credit[k]);
        chk("coin_acc", k, int'(coin_acc_w[k]), int'(e_acc[k]));
        chk("coin_rej", k, int'(coin_rej_w[k]), int'(e_rej[k]));
        chk("err_funds", k, int'(err_funds_w[k]), int'(e_err[k]));
        chk("disp_valid", k, int'(disp_valid_w[k]), int'(e_disp[k]));
        chk("disp_idx", k, int'(disp_idx_w[k]), m_idx[k]);
        chk("change_pulse", k, int'(change_pulse_w[k]), int'(e_chg[k]));
        chk("busy", k, int'(busy_w[k]), int'(e_busy[k]));
      end
    end
  end

  task automatic cyc(input bit cv, input int ca, input bit sv, input int si, input bit cn);
    coin_valid = cv;
    coin_amt   = ca[2:0];
    sel_valid  = sv;
    sel_idx    = si[1:0];
    cancel     = cn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      n_chg[k]  += int'(change_pulse_w[k]);
      n_disp[k] += int'(disp_valid_w[k]);
    end
    coin_valid = 0;
    sel_valid  = 0;
    cancel     = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int a);
    cyc(1, a, 0, 0, 0);
  endtask

  task automatic clr_counts();
    for (int k = 0; k < ND; k++) begin
      n_chg[k] = 0;
      n_disp[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2);
    rst = 0;
    clr_counts();
  endtask

  initial begin
    rst = 1; coin_valid = 0; coin_amt = 0; sel_valid = 0; sel_idx = 0; cancel = 0;
    for (int k = 0; k < ND; k++) begin
      m_credit[k] = 0; m_vleft[k] = 0; m_idle[k] = 0; m_idx[k] = 0; m_refund[k] = 0;
      e_acc[k] = 0; e_rej[k] = 0; e_err[k] = 0; e_chg[k] = 0; e_disp[k] = 0; e_busy[k] = 0;
    end
    clr_counts();
    @(negedge clk);
    chk_en = 1;
    idle(2);
    chk("lit_reset_credit", 0, int'(credit_w[0]), 0);
    chk("lit_reset_busy", 0, int'(busy_w[0]), 0);
    rst = 0;

    // Exact vend: 2+1 = 3, product 0 costs 3.
    coin(2); coin(1);
    chk("lit_credit3", 0, int'(credit_w[0]), 3);
    chk("lit_model_credit3", 0, m_credit[0], 3);
    clr_counts();
    cyc(0, 0, 1, 0, 0);
    idle(5);
    $display("exact vend: disp=%0d chg=%0d credit=%0d", n_disp[0], n_chg[0], credit_w[0]);
    chk("lit_exact_disp", 0, n_disp[0], 3);
    chk("lit_exact_chg", 0, n_chg[0], 0);
    chk("lit_exact_credit", 0, int'(credit_w[0]), 0);

    // Vend with change: 7 - 5 leaves 2.
    do_reset();
    coin(5); coin(2);
    chk("lit_credit7", 0, int'(credit_w[0]), 7);
    clr_counts();
    cyc(0, 0, 1, 2, 0);
    idle(8);
    $display("vend+change: dut0 chg=%0d dut1 credit=%0d", n_chg[0], credit_w[1]);
    chk("lit_change_disp", 0, n_disp[0], 3);
    chk("lit_change_chg", 0, n_chg[0], 2);
    chk("lit_change_credit", 0, int'(credit_w[0]), 0);
    chk("lit_keep_credit", 1, int'(credit_w[1]), 2);
    chk("lit_keep_chg", 1, n_chg[1], 0);
    chk("lit_keep_model", 1, m_credit[1], 2);

    // Saturation and rejection.
    do_reset();
    coin(5); coin(5);
    coin(5);
    chk("lit_sat_rej", 0, int'(coin_rej_w[0]), 1);
    chk("lit_sat_credit", 0, int'(credit_w[0]), 10);
    coin(2);
    chk("lit_sat_acc", 0, int'(coin_acc_w[0]), 1);
    chk("lit_sat_credit12", 0, int'(credit_w[0]), 12);
    coin(0);
    chk("lit_zero_rej", 0, int'(coin_rej_w[0]), 1);
    cyc(0, 0, 1, 0, 0);
    coin(1);
    chk("lit_vend_rej", 0, int'(coin_rej_w[0]), 1);
    $display("saturation: credit after vend=%0d", credit_w[0]);
    idle(15);

    // Errors and priority.
    do_reset();
    coin(3);
    cyc(0, 0, 1, 3, 0);
    chk("lit_err_funds", 0, int'(err_funds_w[0]), 1);
    chk("lit_err_credit", 0, int'(credit_w[0]), 3);
    cyc(1, 2, 0, 0, 1);
    chk("lit_cancel_rej", 0, int'(coin_rej_w[0]), 1);
    clr_counts();
    idle(6);
    $display("cancel: chg=%0d", n_chg[0]);
    chk("lit_cancel_chg", 0, n_chg[0], 3);

    // Reset mid-CHANGE.
    do_reset();
    coin(5);
    cyc(0, 0, 0, 0, 1);
    idle(2);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("lit_rst_credit", 0, int'(credit_w[0]), 0);
      chk("lit_rst_chg", 0, int'(change_pulse_w[0]), 0);
      chk("lit_rst_busy", 0, int'(busy_w[0]), 0);
    end
    rst = 0;
    clr_counts();
    idle(5);
    chk("lit_post_rst_chg", 0, n_chg[0], 0);

    // Timeout on dut2.
    do_reset();
    coin(4);
    idle(7);
    chk("lit_to_not_yet", 2, int'(busy_w[2]), 0);
    idle(1);
    chk("lit_to_fired", 2, int'(busy_w[2]), 1);
    clr_counts();
    idle(6);
    $display("timeout: dut2 chg=%0d dut0 credit=%0d", n_chg[2], credit_w[0]);
    chk("lit_to_chg", 2, n_chg[2], 4);
    chk("lit_to_hold_other", 0, int'(credit_w[0]), 4);
    do_reset();
    coin(4);
    idle(6);
    coin(1);
    idle(7);
    chk("lit_to_restart", 2, int'(busy_w[2]), 0);
    idle(1);
    chk("lit_to_restart_fire", 2, int'(busy_w[2]), 1);
    chk("lit_to_restart_credit", 2, int'(credit_w[2]), 5);

    // Randomised traffic with bursty activity levels.
    do_reset();
    for (int blk = 0; blk < 80; blk++) begin
      int dens;
      dens = $urandom_range(0, 45);
      for (int i = 0; i < 50; i++) begin
        bit cv, sv, cn;
        cv = ($urandom_range(0, 99) < dens);
        sv = ($urandom_range(0, 99) < dens / 4);
        cn = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 599) == 0) rst = 1;
        cyc(cv, $urandom_range(0, 7), sv, $urandom_range(0, 3), cn);
        rst = 0;
      end
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
